// File: rtl/peaks_pkg.sv
// Shared types for the streaming spectral peak picker.
// Holds the bin-index width helper, band-edge element type and FSM states.
package peaks_pkg;

  function automatic int freq_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [31:0] edge_t;

  typedef enum logic [1:0] {
    FILL,
    SCAN,
    EMIT
  } state_t;

endpackage

// File: rtl/frame_ring_buf.sv
// Three-bank frame ring: one write port into the fill bank and
// synchronous reads of the oldest, middle and newest complete frames.
module frame_ring_buf #(
  parameter int FREQS = 256,
  parameter int IN_W  = 24,
  parameter int AW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic signed [IN_W-1:0] wdata,
  input  logic                   rotate,
  input  logic [AW-1:0]          raddr,
  output logic signed [IN_W-1:0] prev,
  output logic signed [IN_W-1:0] curr,
  output logic signed [IN_W-1:0] next
);

  logic signed [IN_W-1:0] mem [3][FREQS];
  logic [1:0] wb;
  logic [1:0] cb;
  logic [1:0] nb;

  // wb is the fill bank, which also holds the oldest complete frame
  assign cb = (wb == 2'd2) ? 2'd0 : wb + 2'd1;
  assign nb = (wb == 2'd0) ? 2'd2 : wb - 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb <= 2'd0;
    end else if (rotate) begin
      wb <= cb;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wb][waddr] <= wdata;
    end
    prev <= mem[wb][raddr];
    curr <= mem[cb][raddr];
    next <= mem[nb][raddr];
  end

endmodule

// File: rtl/peaks_stream.sv
// Streaming peak picker: fills a 3-frame ring, scans the middle frame
// for local maxima and reports the strongest peak per frequency band.
module peaks_stream
  import peaks_pkg::*;
#(
  parameter int FREQS = 256,
  parameter int IN_W = 24,
  parameter int NUM_BANDS = 6,
  parameter edge_t [NUM_BANDS-1:0] BAND_HI =
    {32'd255, 32'd191, 32'd127, 32'd95, 32'd63, 32'd31},
  parameter logic signed [IN_W-1:0] THRESHOLD = '0
) (
  input  logic                                CLOCK_50,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [IN_W-1:0]              in_ampl,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_BANDS*IN_W-1:0]           out_ampl,
  output logic [NUM_BANDS*freq_w(FREQS)-1:0]  out_freq,
  output logic [NUM_BANDS-1:0]                out_band_hit,
  output logic                                frame_err
);

  localparam int FREQ_W = freq_w(FREQS);
  localparam logic [FREQ_W:0] SCAN_LAST = (FREQ_W+1)'(FREQS + 1);
  localparam logic [FREQ_W:0] SCAN_BINS = (FREQ_W+1)'(FREQS);
  localparam logic [FREQ_W-1:0] BIN_LAST = FREQ_W'(FREQS - 1);

  state_t state;
  state_t state_nx;
  logic rdy;
  logic [FREQ_W-1:0] idx;
  logic [1:0] seen;
  logic [FREQ_W:0] scnt;
  logic acc;
  logic at_end;
  logic bad;
  logic we;
  logic done;
  logic scan_end;

  assign in_ready = rdy && (state == FILL);
  assign acc = in_valid && in_ready;
  assign at_end = (idx == BIN_LAST);
  assign bad = acc && (in_last != at_end);
  assign we = acc && !bad;
  assign done = we && in_last;
  assign out_valid = (state == EMIT);
  assign scan_end = (state == SCAN) && (scnt == SCAN_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (done && seen >= 2'd2) state_nx = SCAN;
      SCAN: if (scnt == SCAN_LAST) state_nx = EMIT;
      EMIT: if (out_ready) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= FILL;
      rdy <= 1'b0;
      idx <= '0;
      seen <= 2'd0;
      scnt <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      rdy <= 1'b1;
      if (bad) begin
        idx <= '0;
        frame_err <= 1'b1;
      end else if (we) begin
        idx <= done ? '0 : idx + FREQ_W'(1);
      end
      if (done && seen != 2'd3) begin
        seen <= seen + 2'd1;
      end
      scnt <= (state == SCAN) ? scnt + (FREQ_W+1)'(1) : '0;
    end
  end

  logic signed [IN_W-1:0] rd_prev;
  logic signed [IN_W-1:0] rd_curr;
  logic signed [IN_W-1:0] rd_next;
  logic [FREQ_W-1:0] raddr;

  assign raddr = (scnt < SCAN_BINS) ? scnt[FREQ_W-1:0] : '0;

  frame_ring_buf #(
    .FREQS(FREQS),
    .IN_W (IN_W),
    .AW   (FREQ_W)
  ) u_ring (
    .clk   (CLOCK_50),
    .rst   (reset),
    .we    (we),
    .waddr (idx),
    .wdata (in_ampl),
    .rotate(done),
    .raddr (raddr),
    .prev  (rd_prev),
    .curr  (rd_curr),
    .next  (rd_next)
  );

  // bin f is judged two cycles after its read; rd_curr then holds f+1
  logic signed [IN_W-1:0] c_lo;
  logic signed [IN_W-1:0] c_mid;
  logic signed [IN_W-1:0] p_mid;
  logic signed [IN_W-1:0] n_mid;
  logic [FREQ_W-1:0] fbin;
  logic eval;
  logic peak;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      c_lo <= '0;
      c_mid <= '0;
      p_mid <= '0;
      n_mid <= '0;
    end else begin
      c_lo <= c_mid;
      c_mid <= rd_curr;
      p_mid <= rd_prev;
      n_mid <= rd_next;
    end
  end

  assign fbin = scnt[FREQ_W-1:0] - FREQ_W'(2);
  assign eval = (state == SCAN) && (scnt >= (FREQ_W+1)'(2));
  assign peak = ((fbin == '0) || (c_mid >= c_lo))
             && ((fbin == BIN_LAST) || (c_mid >= rd_curr))
             && (c_mid >= p_mid)
             && (c_mid >= n_mid)
             && (c_mid > THRESHOLD);

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    localparam logic [FREQ_W:0] HI = (FREQ_W+1)'(BAND_HI[b]);
    localparam logic [FREQ_W:0] LO = (b == 0) ? '0 :
      (FREQ_W+1)'(BAND_HI[(b == 0) ? 0 : b - 1] + 32'd1);

    logic above;
    logic in_band;
    logic signed [IN_W-1:0] mx;
    logic signed [IN_W-1:0] mx_nx;
    logic signed [IN_W-1:0] o_mx;
    logic [FREQ_W-1:0] fq;
    logic [FREQ_W-1:0] fq_nx;
    logic [FREQ_W-1:0] o_fq;
    logic hit;
    logic hit_nx;
    logic o_hit;

    if (b == 0) begin : g_lo
      assign above = 1'b1;
    end else begin : g_lo
      assign above = ({1'b0, fbin} >= LO);
    end

    assign in_band = above && ({1'b0, fbin} <= HI);

    // strict > keeps the lowest bin on equal amplitudes
    always_comb begin
      mx_nx = mx;
      fq_nx = fq;
      hit_nx = hit;
      if (state == FILL) begin
        mx_nx = THRESHOLD;
        fq_nx = LO[FREQ_W-1:0];
        hit_nx = 1'b0;
      end else if (eval && peak && in_band && (c_mid > mx)) begin
        mx_nx = c_mid;
        fq_nx = fbin;
        hit_nx = 1'b1;
      end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        mx <= THRESHOLD;
        fq <= LO[FREQ_W-1:0];
        hit <= 1'b0;
        o_mx <= THRESHOLD;
        o_fq <= '0;
        o_hit <= 1'b0;
      end else begin
        mx <= mx_nx;
        fq <= fq_nx;
        hit <= hit_nx;
        if (scan_end) begin
          o_mx <= mx_nx;
          o_fq <= fq_nx;
          o_hit <= hit_nx;
        end
      end
    end

    assign out_ampl[b*IN_W +: IN_W] = o_mx;
    assign out_freq[b*FREQ_W +: FREQ_W] = o_fq;
    assign out_band_hit[b] = o_hit;
  end

endmodule

// File: tb/tb_peaks_stream.sv
// Directed bench for peaks_stream: 16 bins, bands 0-7 / 8-15, threshold 0.
// Expected band results are worked out by hand per vector.
module tb_peaks_stream;

  localparam int FREQS = 16;
  localparam int IN_W = 24;
  localparam int NB = 2;
  localparam int FW = 4;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [IN_W-1:0] in_ampl = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [NB*IN_W-1:0] out_ampl;
  logic [NB*FW-1:0] out_freq;
  logic [NB-1:0] out_band_hit;
  logic frame_err;

  int n_vec = 0;
  int n_err = 0;
  int fr[FREQS];

  peaks_stream #(
    .FREQS    (FREQS),
    .IN_W     (IN_W),
    .NUM_BANDS(NB),
    .BAND_HI  ({32'd15, 32'd7}),
    .THRESHOLD(24'sd0)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ampl     (in_ampl),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ampl    (out_ampl),
    .out_freq    (out_freq),
    .out_band_hit(out_band_hit),
    .frame_err   (frame_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < FREQS; i++) fr[i] = v;
  endtask

  task automatic send_frame(input int n, input int last_at);
    int w;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      in_valid = 1'b1;
      in_ampl = IN_W'(fr[i]);
      in_last = (i == last_at);
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge CLOCK_50);
        w++;
      end
      if (!in_ready) check("in_ready_wait", in_ready, 1);
      @(posedge CLOCK_50);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic no_result(input string tag);
    int hi;
    hi = 0;
    repeat (25) begin
      @(negedge CLOCK_50);
      if (out_valid) hi++;
    end
    check(tag, hi, 0);
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check({tag, "_lat"}, lat, FREQS + 3);
  endtask

  task automatic band(input string tag, input int b,
                      input int a, input int f, input int h);
    check({tag, "_ampl"}, $signed(out_ampl[b*IN_W +: IN_W]), a);
    check({tag, "_freq"}, out_freq[b*FW +: FW], f);
    check({tag, "_hit"}, out_band_hit[b], h);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge CLOCK_50);
    #1 out_ready = 1'b0;
    @(negedge CLOCK_50);
    check({tag, "_vld_drop"}, out_valid, 0);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_ampl"}, out_ampl, 0);
    check({tag, "_freq"}, out_freq, 0);
    check({tag, "_hit"}, out_band_hit, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NB*(IN_W+FW+1)-1:0] snap;
    int chg;

    repeat (3) @(negedge CLOCK_50);
    reset_vals("rst");
    reset = 1'b0;
    #1 check("rdy_before_edge", in_ready, 0);
    @(negedge CLOCK_50);
    check("rdy_after_edge", in_ready, 1);

    set_all(0);
    send_frame(FREQS, FREQS - 1);
    no_result("t1_f0_none");
    fr[5] = 100;
    send_frame(FREQS, FREQS - 1);
    no_result("t1_f1_none");
    set_all(0);
    send_frame(FREQS, FREQS - 1);
    wait_result("t1");
    band("t1_b0", 0, 100, 5, 1);
    band("t1_b1", 1, 0, 8, 0);

    snap = {out_ampl, out_freq, out_band_hit};
    in_valid = 1'b1;
    in_ampl = 24'sd999;
    in_last = 1'b1;
    chg = 0;
    repeat (50) begin
      @(negedge CLOCK_50);
      if ({out_ampl, out_freq, out_band_hit} != snap || !out_valid) chg++;
    end
    check("hold_stable", chg, 0);
    check("hold_in_ready", in_ready, 0);
    in_valid = 1'b0;
    in_last = 1'b0;
    take("t1");
    check("t1_rdy_back", in_ready, 1);

    set_all(0);
    fr[3] = 50;
    fr[6] = 50;
    send_frame(FREQS, FREQS - 1);
    wait_result("t3a");
    band("t3a_b0", 0, 0, 0, 0);
    band("t3a_b1", 1, 0, 8, 0);
    take("t3a");
    set_all(0);
    send_frame(FREQS, FREQS - 1);
    wait_result("t3");
    band("t3_b0", 0, 50, 3, 1);
    band("t3_b1", 1, 0, 8, 0);
    take("t3");

    set_all(1);
    fr[0] = 9;
    fr[15] = 9;
    send_frame(FREQS, FREQS - 1);
    wait_result("t4a");
    band("t4a_b1", 1, 0, 8, 0);
    take("t4a");
    set_all(0);
    send_frame(FREQS, FREQS - 1);
    wait_result("t4");
    band("t4_b0", 0, 9, 0, 1);
    band("t4_b1", 1, 9, 15, 1);
    take("t4");

    set_all(0);
    fr[2] = 77;
    send_frame(11, 10);
    #1 check("t5_frame_err", frame_err, 1);
    no_result("t5_drop_none");
    set_all(0);
    fr[12] = 40;
    send_frame(FREQS, FREQS - 1);
    wait_result("t5a");
    band("t5a_b0", 0, 0, 0, 0);
    band("t5a_b1", 1, 0, 8, 0);
    take("t5a");
    set_all(0);
    send_frame(FREQS, FREQS - 1);
    wait_result("t5");
    band("t5_b0", 0, 0, 0, 0);
    band("t5_b1", 1, 40, 12, 1);
    check("t5_err_sticky", frame_err, 1);
    take("t5");

    send_frame(FREQS, FREQS - 1);
    repeat (5) @(negedge CLOCK_50);
    reset = 1'b1;
    #1 reset_vals("midrst");
    @(negedge CLOCK_50);
    reset = 1'b0;

    send_frame(FREQS, -1);
    #1 check("t6_no_last_err", frame_err, 1);
    send_frame(FREQS, FREQS - 1);
    no_result("t6_f0_none");
    fr[9] = 30;
    fr[1] = -5;
    send_frame(FREQS, FREQS - 1);
    no_result("t6_f1_none");
    set_all(0);
    send_frame(FREQS, FREQS - 1);
    wait_result("t6");
    band("t6_b0", 0, 0, 0, 0);
    band("t6_b1", 1, 30, 9, 1);
    take("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
